// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with a 2-entry skid buffer.
//
// Sits between adjacent core stages (F/D, D/E, E/M, M/W) and carries an
// arbitrary packed payload under a valid/ready handshake. The head register
// feeds out_data; the skid register catches the one extra payload that can
// arrive while in_ready is still high from the previous cycle. This lets
// in_ready come straight from a flop with no combinational path from
// out_ready, without losing throughput.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   flush               empty the buffer; payload offered this cycle is dropped
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake (out_valid registered)
//   out_data            head payload, NOP_VALUE while out_valid=0
//   occupancy           entries held (0..2)
//   stall_cnt           cycles with out_valid && !out_ready (saturating)
//   bubble_cnt          cycles with !out_valid (saturating)
//
// Optional feature macro: PIPE_STAGE_STATS_EN adds stall_cnt/bubble_cnt.
// Without it those ports and the counter logic do not exist.

module pipe_stage_buf #(
    parameter int               WIDTH     = 161,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;

    logic accept;
    logic drain;

    // in_ready/out_valid are flops that mirror the state, so these two
    // terms only see registered signals and the local handshake inputs.
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    assign occupancy = state;
    assign out_data  = out_valid ? head : NOP_VALUE;

    // in_ready and out_valid are updated alongside every state change so
    // they always equal (state != TWO) and (state != EMPTY) respectively.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= EMPTY;
            head      <= NOP_VALUE;
            skid      <= NOP_VALUE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Overrides any same-cycle accept; a same-cycle drain has already
            // been taken downstream and simply is not re-presented.
            state     <= EMPTY;
            head      <= NOP_VALUE;
            skid      <= NOP_VALUE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head      <= in_data;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head <= in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind head
                        // and close the input next cycle.
                        skid     <= in_data;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (drain) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        head     <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counters watch the registered handshake every cycle, flush included;
    // only reset clears them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int          W   = 16;
    localparam logic [15:0] NOP = 16'hDEAD;
`ifdef PIPE_STAGE_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
`endif

    pipe_stage_buf #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two payloads plus two counters.
    logic [15:0] q[$];
    int          stall_m  = 0;
    int          bubble_m = 0;
    int          cnt_max  = (1 << CNT_W) - 1;
    bit          last_acc;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("out_data",  32'(out_data),  32'((q.size() != 0) ? q[0] : NOP));
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt",  32'(stall_cnt),  32'(stall_m));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(bubble_m));
`endif
    endtask

    // Apply one cycle of inputs, advance the model over the edge, then check.
    task automatic step(input bit rn, input bit fl, input bit iv,
                        input logic [15:0] d, input bit ordy);
        bit acc, drn;
        reset_n = rn; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        acc = iv && (q.size() < 2);
        drn = (q.size() != 0) && ordy;
        if (!rn) begin
            stall_m = 0; bubble_m = 0;
        end else begin
            if (q.size() != 0 && !ordy && stall_m < cnt_max) stall_m++;
            if (q.size() == 0 && bubble_m < cnt_max) bubble_m++;
        end
        if (!rn || fl) begin
            q.delete();
            last_acc = 1'b0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(d);
            last_acc = acc;
        end
        #1 check_all();
    endtask

    initial begin
        logic [15:0] pend;
        bit          pv;

        // Reset held two cycles while upstream offers 0x1234.
        step(0, 0, 1, 16'h1234, 0);
        step(0, 0, 1, 16'h1234, 0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_data", 32'(out_data), 32'(NOP));
        // First accept after release, then drain.
        step(1, 0, 1, 16'h1234, 0);
        chk("first_data", 32'(out_data), 32'h1234);
        step(1, 0, 0, 16'h0, 1);

        // Streaming 1..4 with out_ready high.
        for (int i = 1; i <= 4; i++) step(1, 0, 1, 16'(i), 1);
        step(1, 0, 0, 16'h0, 1);

        // Backpressure: A,B accepted, C held upstream, then release.
        step(1, 0, 1, 16'hA0A0, 0);
        step(1, 0, 1, 16'hB0B0, 0);
        step(1, 0, 1, 16'hC0C0, 0);
        chk("bp_full", 32'(occupancy), 32'd2);
        step(1, 0, 1, 16'hC0C0, 1);
        step(1, 0, 1, 16'hC0C0, 1);
        step(1, 0, 0, 16'h0, 1);
        step(1, 0, 0, 16'h0, 1);

        // Flush with a full buffer and a simultaneous offer.
        step(1, 0, 1, 16'h1111, 0);
        step(1, 0, 1, 16'h2222, 0);
        step(1, 1, 1, 16'h3333, 1);
        chk("flush_data", 32'(out_data), 32'(NOP));
        step(1, 0, 0, 16'h0, 1);

        // Reset wins over flush with a full buffer, then resume.
        step(1, 0, 1, 16'h4444, 0);
        step(1, 0, 1, 16'h5555, 0);
        step(0, 1, 1, 16'h6666, 1);
        step(1, 0, 1, 16'h7777, 1);
        step(1, 0, 1, 16'h8888, 1);
        step(1, 0, 0, 16'h0, 1);

`ifdef PIPE_STAGE_STATS_EN
        // Counter saturation and flush not clearing counters.
        step(0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 16'h0, 0);
        step(1, 0, 1, 16'h0101, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0, 0);
        chk("stall_sat", 32'(stall_cnt), 32'd3);
        step(1, 1, 0, 16'h0, 0);
        chk("stall_flush", 32'(stall_cnt), 32'd3);
`endif

        // Randomized traffic; upstream holds its payload until accepted.
        pv = 1'b0; pend = '0;
        for (int i = 0; i < 400; i++) begin
            bit rn, fl, ordy;
            if (!pv || last_acc) begin
                pv   = ($urandom_range(0, 3) != 0);
                pend = 16'($urandom);
            end
            rn   = ($urandom_range(0, 63) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            step(rn, fl, pv, pend, ordy);
            if (!rn || fl) pv = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register that replaces the fixed-field stage registers between adjacent stages of the 5-stage MIPS core (F/D, D/E, E/M, M/W). It carries an arbitrary-width packed payload (PC, instruction, operands, control bits) with a valid/ready handshake. A 2-entry skid buffer keeps full throughput while the in_ready path stays registered. Flush inserts a bubble whose payload is a configurable NOP pattern.

## Interface
Parameters:
- WIDTH, 161: payload width in bits (default = PC + Instr + ext32 + rs_data + rt_data + b_jump).
- NOP_VALUE, {WIDTH{1'b0}}: payload presented on out_data whenever out_valid=0.
- CNT_W, 16: width of statistics counters (used only under PIPE_STAGE_STATS_EN).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset_n  input  1  synchronous, active-low reset (sampled on clk rising edge).
- flush  input  1  discard all held entries this cycle.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  buffer can accept; registered (no combinational path from out_ready).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head payload; NOP_VALUE when out_valid=0.
- occupancy  output  2  entries held (0, 1 or 2).
- stall_cnt  output  CNT_W  PIPE_STAGE_STATS_EN only.
- bubble_cnt  output  CNT_W  PIPE_STAGE_STATS_EN only.

## Operation
- Storage: main register (head) + skid register. State = EMPTY / ONE / TWO, encoded in occupancy.
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- Transitions (no flush):
  - EMPTY: accept → ONE (head ← in_data).
  - ONE: accept & drain → ONE (head ← in_data). Accept only → TWO (skid ← in_data). Drain only → EMPTY.
  - TWO: drain → ONE (head ← skid). in_ready=0, so no accept is possible.
- in_ready = (occupancy != 2), driven from a register.
- out_valid = (occupancy != 0). out_data = head when valid, else NOP_VALUE.
- Strict FIFO order; no payload is ever dropped or duplicated except by flush.
- flush: next state EMPTY, head and skid ← NOP_VALUE. flush overrides a simultaneous accept and drain; the upstream payload offered that cycle is discarded. A drain on the flush cycle still counts as completed downstream.
- Reset (reset_n=0 at a clk edge), which overrides flush: occupancy=0, out_valid=0, in_ready=1, out_data=NOP_VALUE, head/skid=NOP_VALUE, counters=0. Reset mid-transfer discards all held entries.

## Timing
- Latency: payload accepted at edge N appears on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 payload/cycle sustained while out_ready=1. in_ready deasserts the cycle after the buffer reaches TWO.
- First cycle after reset release: in_ready=1, out_valid=0.
- Flush at edge N: out_valid=0 and in_ready=1 from cycle N+1.
- All outputs are registered except out_data, which is a mux of head and NOP_VALUE by registered state.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt and bubble_cnt ports exist.
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both saturate at 2^CNT_W−1 and clear only on reset, not on flush.
- Not defined: both ports and all counter logic are absent; the remaining behaviour is identical.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with in_valid=1, in_data=0x1234 → occupancy=0, out_valid=0, in_ready=1, out_data=NOP_VALUE. After release, the first accept of 0x1234 gives out_data=0x1234 one cycle later.
- Streaming: out_ready=1, inputs 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on consecutive cycles, in_ready stays 1, occupancy stays ≤1.
- Backpressure: out_ready=0, offer A,B,C → A and B accepted, occupancy=2, in_ready=0, C held upstream. Raise out_ready → output order A,B,C with no loss.
- Flush with simultaneous accept: occupancy=2 (A,B), assert flush with in_valid=1 (C) → next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE, C never appears.
- Reset beats flush: reset_n=0 and flush=1 together with occupancy=2 → reset values. Then resume streaming normally.
- Stats (macro defined, CNT_W=2): 5 stall cycles → stall_cnt=3 (saturated). 2 empty cycles → bubble_cnt increments by 2. Flush leaves both counters unchanged.
